// File: rtl/aes_sbox_sched.sv
// Shares LANES S-box lanes between the cipher SubBytes client (128-bit) and the key-schedule
// SubWord client (32-bit): round-robin grant, beat slicing, result reassembly and per-client return.
module aes_sbox_sched #(
  parameter int LANES = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               st_req_valid_i,
  output logic               st_req_ready_o,
  input  logic [127:0]       st_req_data_i,
  output logic               st_rsp_valid_o,
  input  logic               st_rsp_ready_i,
  output logic [127:0]       st_rsp_data_o,
  input  logic               key_req_valid_i,
  output logic               key_req_ready_o,
  input  logic [31:0]        key_req_data_i,
  output logic               key_rsp_valid_o,
  input  logic               key_rsp_ready_i,
  output logic [31:0]        key_rsp_data_o,
  output logic               sbox_start_o,
  output logic [8*LANES-1:0] sbox_in_o,
  input  logic               sbox_finish_i,
  input  logic [8*LANES-1:0] sbox_out_i
);

  localparam int CW        = 5;
  localparam int ST_BEATS  = 16 / LANES;
  localparam int KEY_BEATS = (LANES >= 4) ? 1 : 4 / LANES;

  typedef enum logic [2:0] {IDLE, SUB_ST, SUB_KEY, DONE_ST, DONE_KEY} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_key_q;
  logic [127:0]    st_data_q, st_rsp_q;
  logic [31:0]     key_data_q, key_rsp_q;
  logic            idle, in_sub, key_job, last_beat, st_acc, key_acc;
  logic [5:0]      lane_idx [LANES];

  assign idle    = (state_q == IDLE);
  assign in_sub  = (state_q == SUB_ST) || (state_q == SUB_KEY);
  assign key_job = (state_q == SUB_KEY);

  // On a tie the client that did not win last time gets the grant.
  assign key_req_ready_o = idle && key_req_valid_i && (!st_req_valid_i || !last_key_q);
  assign st_req_ready_o  = idle && st_req_valid_i && (!key_req_valid_i || last_key_q);
  assign st_acc  = st_req_valid_i && st_req_ready_o;
  assign key_acc = key_req_valid_i && key_req_ready_o;

  assign last_beat = key_job ? (cnt_q == CW'(KEY_BEATS - 1)) : (cnt_q == CW'(ST_BEATS - 1));
  assign cnt_d     = last_beat ? '0 : cnt_q + 1'b1;

  assign sbox_start_o    = in_sub;
  assign st_rsp_valid_o  = (state_q == DONE_ST);
  assign key_rsp_valid_o = (state_q == DONE_KEY);
  assign st_rsp_data_o   = st_rsp_q;
  assign key_rsp_data_o  = key_rsp_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_idx[gi] = 6'(cnt_q) * 6'(LANES) + 6'(gi);
    // Key jobs only cover bytes 0..3; wider lanes idle at zero.
    assign sbox_in_o[8*gi +: 8] = !in_sub ? 8'h00 :
                                  key_job ? ((lane_idx[gi] < 6'd4) ? key_data_q[8*lane_idx[gi][1:0] +: 8] : 8'h00) :
                                  st_data_q[8*lane_idx[gi][3:0] +: 8];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_key_q <= 1'b0;
      st_data_q  <= '0;
      key_data_q <= '0;
      st_rsp_q   <= '0;
      key_rsp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (key_acc) begin
            key_data_q <= key_req_data_i;
            last_key_q <= 1'b1;
            state_q    <= SUB_KEY;
          end else if (st_acc) begin
            st_data_q  <= st_req_data_i;
            last_key_q <= 1'b0;
            state_q    <= SUB_ST;
          end
        end
        SUB_ST, SUB_KEY: begin
          if (sbox_finish_i) begin
            for (int k = 0; k < LANES; k++) begin
              if (key_job) begin
                if (lane_idx[k] < 6'd4)
                  key_rsp_q[8*lane_idx[k][1:0] +: 8] <= sbox_out_i[8*k +: 8];
              end else begin
                st_rsp_q[8*lane_idx[k][3:0] +: 8] <= sbox_out_i[8*k +: 8];
              end
            end
            cnt_q <= cnt_d;
            if (last_beat) state_q <= key_job ? DONE_KEY : DONE_ST;
          end
        end
        DONE_ST:  if (st_rsp_ready_i)  state_q <= IDLE;
        DONE_KEY: if (key_rsp_ready_i) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Directed bench for aes_sbox_sched (LANES=4) with an AES S-box table standing in for the lane array.
module tb_aes_sbox_sched;
  localparam int LANES = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic st_req_valid, st_req_ready, st_rsp_valid, st_rsp_ready;
  logic [127:0] st_req_data, st_rsp_data;
  logic key_req_valid, key_req_ready, key_rsp_valid, key_rsp_ready;
  logic [31:0] key_req_data, key_rsp_data;
  logic sbox_start, fin;
  logic [8*LANES-1:0] sbox_in, sbox_out;

  int passed = 0;
  int total  = 0;

  logic [7:0] sbox_tbl [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  always_comb begin
    sbox_out = '0;
    for (int k = 0; k < LANES; k++) sbox_out[8*k +: 8] = sbox_tbl[sbox_in[8*k +: 8]];
  end

  always #5 clk = ~clk;

  aes_sbox_sched #(.LANES(LANES)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .st_req_valid_i(st_req_valid), .st_req_ready_o(st_req_ready), .st_req_data_i(st_req_data),
    .st_rsp_valid_o(st_rsp_valid), .st_rsp_ready_i(st_rsp_ready), .st_rsp_data_o(st_rsp_data),
    .key_req_valid_i(key_req_valid), .key_req_ready_o(key_req_ready), .key_req_data_i(key_req_data),
    .key_rsp_valid_o(key_rsp_valid), .key_rsp_ready_i(key_rsp_ready), .key_rsp_data_o(key_rsp_data),
    .sbox_start_o(sbox_start), .sbox_in_o(sbox_in), .sbox_finish_i(fin), .sbox_out_i(sbox_out)
  );

  localparam logic [127:0] ST_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] ST_EXP = 128'h76abd7fe2b670130c56f6bf27b777c63;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_rsp(input bit is_key, output int n, output bit other);
    n = 0;
    other = 1'b0;
    do begin
      tick();
      n++;
      if (is_key ? st_rsp_valid : key_rsp_valid) other = 1'b1;
    end while (!(is_key ? key_rsp_valid : st_rsp_valid) && n < 50);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, m, g, hs;
    bit other, both, seen;
    bit order [4];

    rst_n = 1'b0; fin = 1'b1;
    st_req_valid = 0; st_req_data = '0; st_rsp_ready = 0;
    key_req_valid = 0; key_req_data = '0; key_rsp_ready = 0;
    repeat (3) tick();
    chk("reset_valids", {st_rsp_valid, key_rsp_valid, sbox_start, st_req_ready, key_req_ready}, 0);
    chk("reset_sbox_in", sbox_in, 0);
    chk("reset_st_data", st_rsp_data, 0);
    chk("reset_key_data", key_rsp_data, 0);
    rst_n = 1'b1;
    tick();

    // 1: state SubBytes, latency 4
    st_req_data = ST_IN; st_req_valid = 1; #1;
    chk("t1_st_ready", st_req_ready, 1);
    tick();
    st_req_valid = 0;
    chk("t1_start", sbox_start, 1);
    chk("t1_beat0_in", sbox_in, 32'h03020100);
    wait_rsp(0, n, other);
    chk("t1_latency", n, 4);
    chk("t1_key_valid_low", other, 0);
    chk("t1_data", st_rsp_data, ST_EXP);
    chk("t1_start_done", sbox_start, 0);
    st_rsp_ready = 1; tick(); st_rsp_ready = 0;
    chk("t1_valid_drop", st_rsp_valid, 0);

    // 2: key SubWord, latency 1
    key_req_data = 32'h53ff0100; key_req_valid = 1; #1;
    chk("t2_key_ready", key_req_ready, 1);
    tick();
    key_req_valid = 0;
    wait_rsp(1, n, other);
    chk("t2_latency", n, 1);
    chk("t2_data", key_rsp_data, 32'hed167c63);
    key_rsp_ready = 1; tick(); key_rsp_ready = 0;
    chk("t2_valid_drop", key_rsp_valid, 0);

    // 3: both valid from reset, round-robin key first
    rst_n = 0; tick(); rst_n = 1;
    st_req_valid = 1; key_req_valid = 1; st_rsp_ready = 1; key_rsp_ready = 1; #1;
    g = 0; hs = 0; both = 0;
    for (int c = 0; c < 100 && g < 4; c++) begin
      if (st_req_ready && key_req_ready) both = 1;
      if (key_req_ready || st_req_ready) begin
        chk("t3_hs_before_grant", hs, g);
        order[g] = key_req_ready;
        g++;
      end
      if ((key_rsp_valid && key_rsp_ready) || (st_rsp_valid && st_rsp_ready)) hs++;
      if (g < 4) tick();
    end
    tick();
    st_req_valid = 0; key_req_valid = 0;
    repeat (8) tick();
    chk("t3_grant_count", g, 4);
    chk("t3_both_ready", both, 0);
    chk("t3_order", {order[0], order[1], order[2], order[3]}, 4'b1010);
    st_rsp_ready = 0; key_rsp_ready = 0;

    // 4: state result held while rsp_ready low
    st_req_data = ST_IN; st_req_valid = 1; tick(); st_req_valid = 0;
    wait_rsp(0, n, other);
    chk("t4_latency", n, 4);
    st_req_valid = 1; st_req_data = '1; key_req_valid = 1; key_req_data = 32'h53ff0100; #1;
    for (int c = 0; c < 10; c++) begin
      chk("t4_hold_valid", st_rsp_valid, 1);
      chk("t4_hold_data", st_rsp_data, ST_EXP);
      chk("t4_no_ready", {st_req_ready, key_req_ready}, 0);
      tick();
    end
    st_req_valid = 0;
    st_rsp_ready = 1; tick(); st_rsp_ready = 0;
    chk("t4_valid_drop", st_rsp_valid, 0);
    chk("t4_key_ready_after", key_req_ready, 1);
    tick();
    key_req_valid = 0;
    wait_rsp(1, n, other);
    chk("t4_key_latency", n, 1);
    chk("t4_key_data", key_rsp_data, 32'hed167c63);
    key_rsp_ready = 1; tick(); key_rsp_ready = 0;

    // 5: finish low for 3 cycles in second beat
    st_req_data = ST_IN; st_req_valid = 1; tick(); st_req_valid = 0;
    tick();
    fin = 0;
    for (int c = 0; c < 3; c++) begin
      chk("t5_stall_in", sbox_in, 32'h07060504);
      chk("t5_stall_start", sbox_start, 1);
      tick();
    end
    fin = 1;
    wait_rsp(0, m, other);
    chk("t5_latency", 4 + m, 7);
    chk("t5_data", st_rsp_data, ST_EXP);
    st_rsp_ready = 1; tick(); st_rsp_ready = 0;

    // 6: reset mid-job
    st_req_data = ST_IN; st_req_valid = 1; tick(); st_req_valid = 0;
    tick();
    chk("t6_beat1_in", sbox_in, 32'h07060504);
    rst_n = 0; tick();
    chk("t6_rst_flags", {st_rsp_valid, key_rsp_valid, sbox_start, st_req_ready, key_req_ready}, 0);
    chk("t6_rst_in", sbox_in, 0);
    chk("t6_rst_st_data", st_rsp_data, 0);
    chk("t6_rst_key_data", key_rsp_data, 0);
    rst_n = 1;
    seen = 0;
    repeat (6) begin
      tick();
      if (st_rsp_valid || sbox_start) seen = 1;
    end
    chk("t6_no_rsp", seen, 0);
    key_req_data = 32'h00000000; key_req_valid = 1; #1;
    chk("t6_key_ready", key_req_ready, 1);
    tick();
    key_req_valid = 0;
    wait_rsp(1, n, other);
    chk("t6_key_latency", n, 1);
    chk("t6_key_data", key_rsp_data, 32'h63636363);
    key_rsp_ready = 1; tick(); key_rsp_ready = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
